seq_alu_responder: RTL
======================

Name: seq_alu_responder

Overview:
Multi-cycle, handshaked responder for the 8-bit ALU operation set (add, subtract, multiply, divide). A requester issues an operand/opcode request on the request channel. The block computes sequentially, using shift-add multiply and restoring divide, and returns a full-width result on the response channel. It keeps the existing positive-only conventions: subtract and divide swap operands so the larger is on the left, and the swap is reported.

Parameters:
WIDTH, 8, operand width; result is 2*WIDTH; mul/div iteration count = WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept request
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_code  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 1xx illegal
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_result  output  2*WIDTH  result
rsp_swap  output  1  operands were swapped (sub/div only)
rsp_err  output  1  illegal opcode or divide by zero
ops_done  output  16  completed-response count (optional feature)

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_swap=0; rsp_err=0; ops_done=0.
  - Reset overrides everything, including mid-operation and pending response. Any in-flight operation is dropped with no response.
- States: IDLE, MUL, DIV, RESP.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. req_ready=1 only in IDLE. Operands and opcode are latched at acceptance; later input changes are ignored.
- swap = (code is sub or div) && (A < B). Let L = swap ? B : A and R = swap ? A : B.
- add: result = zero-extended A+B; carry lands in bit WIDTH. IDLE->RESP. rsp_valid=1 the cycle after acceptance.
- sub: result = zero-extended L-R (never negative). IDLE->RESP, latency 1.
- illegal opcode (1xx): result=0, err=1, swap=0. Latency 1.
- div with R==0: result=0, err=1. Latency 1; DIV state is not entered.
- mul: IDLE->MUL.
  - Exactly WIDTH iteration cycles of shift-add on A*B.
  - MUL->RESP, result = full 2*WIDTH product.
  - rsp_valid=1 WIDTH+1 cycles after acceptance (9 for WIDTH=8).
- div: IDLE->DIV.
  - WIDTH cycles of restoring division of L by R.
  - result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}. Latency WIDTH+1.
- RESP:
  - rsp_valid=1; result/swap/err stable until the handshake.
  - On rsp_valid && rsp_ready: go to IDLE, rsp_valid=0 next cycle, req_ready=1 next cycle.
  - No same-cycle response-accept and new-request-accept.
- rsp_result/rsp_swap/rsp_err hold their last value when rsp_valid=0. They are not cleared except by reset.
- ALU wrap: none. Result width is always sufficient (2*WIDTH).

Optional Feature:
SEQ_ALU_PERF_EN:
- Defined: ops_done increments by 1 on each response handshake and wraps 0xFFFF->0x0000. Error responses are counted.
- Undefined: ops_done is tied to 0 and no counter register is built.

Test Plan:
- Reset, then add A=0xC8 B=0x64 with rsp_ready=1 -> rsp_valid 1 cycle after accept, result=0x012C, swap=0, err=0.
- Sub A=0x10 B=0x30 -> result=0x0020, swap=1. Sub A=0x30 B=0x10 -> result=0x0020, swap=0.
- Mul A=0xFF B=0xFF -> req_ready=0 during MUL, rsp_valid exactly 9 cycles after accept, result=0xFE01.
- Div A=0x07 B=0x64 -> swap=1, result=0x020E (100/7 = 14 r 2), latency 9. Div A=0x05 B=0x00 -> err=1, result=0, latency 1. Code 3'b101 -> err=1, result=0.
- Backpressure: mul 0x0C*0x0A with rsp_ready=0 for 5 cycles after rsp_valid -> result held at 0x0078, req_ready=0 throughout; rsp_ready=1 -> rsp_valid=0 and req_ready=1 next cycle. With SEQ_ALU_PERF_EN defined, ops_done increments by 1.
- Reset mid-op: start div A=0xFF B=0x03, assert rst 4 cycles later -> next cycle rsp_valid=0, req_ready=1, ops_done=0, no response emitted. A fresh add 0x01+0x01 -> 0x0002.

Source files
------------

// File: rtl/seq_alu_responder.sv
// Sequential 8-bit-class ALU responder: add/sub/mul (shift-add)/div (restoring), positive-only with operand swap.
// Latency: add/sub/illegal/div-by-zero respond 1 cycle after accept, mul/div WIDTH+1 cycles after accept.
// Backpressure: one op in flight; response held stable until rsp_ready; optional SEQ_ALU_PERF_EN builds ops_done.
module seq_alu_responder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [2:0]           req_code,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_swap,
    output logic                 rsp_err,
    output logic [15:0]          ops_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, RESP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 pend_swap;

    logic                 req_fire;
    logic                 rsp_fire;
    logic                 code_add;
    logic                 code_sub;
    logic                 code_mul;
    logic                 code_div;
    logic                 code_ill;
    logic                 req_swap;
    logic [WIDTH-1:0]     req_l;
    logic [WIDTH-1:0]     req_r;
    logic                 div_zero;
    logic                 last_iter;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_nxt;

    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign code_ill  = req_code[2];
    assign code_add  = (req_code == 3'b000);
    assign code_sub  = (req_code == 3'b001);
    assign code_mul  = (req_code == 3'b010);
    assign code_div  = (req_code == 3'b011);
    assign req_swap  = (code_sub || code_div) && (req_a < req_b);
    assign req_l     = req_swap ? req_b : req_a;
    assign req_r     = req_swap ? req_a : req_b;
    assign div_zero  = code_div && (req_r == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Multiply: acc = {partial sum, remaining multiplier bits}; add A on LSB, shift right.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left one bit and trial-subtract.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift[WIDTH-1:0] - opb;
    assign div_nxt   = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_fire) begin
                    if (code_mul) begin
                        state_nxt = MUL;
                    end else if (code_div && !div_zero) begin
                        state_nxt = DIV;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Response fields only change when a new result is produced, so they hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            cnt        <= '0;
            pend_swap  <= 1'b0;
            rsp_result <= '0;
            rsp_swap   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_fire) begin
                        opa       <= req_a;
                        opb       <= req_r;
                        cnt       <= '0;
                        pend_swap <= req_swap;
                        if (code_ill) begin
                            rsp_result <= '0;
                            rsp_swap   <= 1'b0;
                            rsp_err    <= 1'b1;
                        end else if (code_add) begin
                            rsp_result <= (2*WIDTH)'(req_a) + (2*WIDTH)'(req_b);
                            rsp_swap   <= 1'b0;
                            rsp_err    <= 1'b0;
                        end else if (code_sub) begin
                            rsp_result <= (2*WIDTH)'(req_l - req_r);
                            rsp_swap   <= req_swap;
                            rsp_err    <= 1'b0;
                        end else if (code_mul) begin
                            acc <= {{WIDTH{1'b0}}, req_b};
                        end else if (div_zero) begin
                            rsp_result <= '0;
                            rsp_swap   <= req_swap;
                            rsp_err    <= 1'b1;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, req_l};
                        end
                    end
                end
                MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        rsp_result <= mul_nxt;
                        rsp_swap   <= 1'b0;
                        rsp_err    <= 1'b0;
                    end
                end
                DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        rsp_result <= div_nxt;
                        rsp_swap   <= pend_swap;
                        rsp_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ALU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= '0;
        end else if (rsp_fire) begin
            ops_done <= ops_done + 16'd1;
        end
    end
`else
    assign ops_done = '0;
`endif

endmodule
